// File: rtl/hex_display_ctrl.sv
// Registered multi-digit active-low 7-segment driver: hex decode, leading-zero blanking and blink.
// Optional nibble-rotate scroll mode is compiled in when HEXDISP_SCROLL_EN is defined.
module hex_display_ctrl #(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_mask,
`ifdef HEXDISP_SCROLL_EN
    input  logic                    scroll_en,
`endif
    output logic [7*N_DIGITS-1:0]   seg,
    output logic                    blink_phase
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic                    wrap;
    logic                    lz_en;
    logic [4*N_DIGITS-1:0]   value_p0;
    logic [7*N_DIGITS-1:0]   seg_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

`ifdef HEXDISP_SCROLL_EN
    // Shift-and-or form also degenerates correctly to identity for a single digit.
    function automatic logic [4*N_DIGITS-1:0] rotl_nibble(input logic [4*N_DIGITS-1:0] v);
        return (v << 4) | (v >> (4 * (N_DIGITS - 1)));
    endfunction

    assign lz_en = blank_lz & ~scroll_en;
`else
    assign lz_en = blank_lz;
`endif

    assign wrap = (div_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            div_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            div_cnt     <= div_cnt + 1'b1;
        end
    end

    // Stage p0: value register
    always_ff @(posedge clk) begin
        if (rst) begin
            value_p0 <= '0;
        end else if (load) begin
            value_p0 <= data;
`ifdef HEXDISP_SCROLL_EN
        end else if (scroll_en && wrap) begin
            value_p0 <= rotl_nibble(value_p0);
`endif
        end
    end

    // Walk from the MS digit down so upper_zero covers nibbles i..N_DIGITS-1.
    always_comb begin
        logic upper_zero;
        logic dark;
        seg_d      = '1;
        upper_zero = 1'b1;
        dark       = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (value_p0[4*i +: 4] == 4'h0);
            dark = (lz_en && upper_zero && (i > 0)) || (blink_phase && blink_mask[i]);
            seg_d[7*i +: 7] = dark ? 7'h7F : hex_decode(value_p0[4*i +: 4]);
        end
    end

    // Stage p1: segment output register
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '1;
        end else begin
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (N_DIGITS=6, BLINK_DIV=4); the scroll scenario runs when HEXDISP_SCROLL_EN is defined.
module tb_hex_display_ctrl;

    localparam int N = 6;
    localparam int D = 4;
`ifdef HEXDISP_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [23:0]   data;
    logic          blank_lz;
    logic [5:0]    blink_mask;
    logic          scroll_en;
    logic [41:0]   seg;
    logic          blink_phase;

    typedef struct {
        logic [41:0] seg;
        logic        ph;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          stim_done = 1'b0;
    bit          report_done = 1'b0;

    // reference model state: current value and edges since last reset
    logic [23:0] mval;
    int          nedge;

    always #5 clk = ~clk;

    hex_display_ctrl #(.N_DIGITS(N), .BLINK_DIV(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data        (data),
        .blank_lz    (blank_lz),
        .blink_mask  (blink_mask),
`ifdef HEXDISP_SCROLL_EN
        .scroll_en   (scroll_en),
`endif
        .seg         (seg),
        .blink_phase (blink_phase)
    );

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[v];
    endfunction

    function automatic logic [41:0] model_seg(input logic [23:0] v, input bit bl,
                                              input logic [5:0] mk, input bit ph, input bit sc);
        logic [41:0] s;
        int          digit;
        bit          dark;
        s = '1;
        for (int i = 0; i < N; i++) begin
            digit = int'((v >> (4 * i)) & 24'hF);
            dark  = (bl && !sc && i > 0 && (v >> (4 * i)) == 24'd0) || (ph && mk[i]);
            s[7*i +: 7] = dark ? 7'h7F : glyph(digit);
        end
        return s;
    endfunction

    task automatic step(input bit r, input bit ld, input logic [23:0] d,
                        input bit bl, input logic [5:0] mk, input bit sc);
        exp_t x;
        bit   sc_eff;
        sc_eff     = SCROLL & sc;
        rst        = r;
        load       = ld;
        data       = d;
        blank_lz   = bl;
        blink_mask = mk;
        scroll_en  = sc;
        if (r) begin
            x.seg = '1;
            mval  = 24'd0;
            nedge = 0;
        end else begin
            x.seg = model_seg(mval, bl, mk, ((nedge / D) % 2) == 1, sc_eff);
            nedge++;
            if (ld)
                mval = d;
            else if (sc_eff && (nedge % D) == 0)
                mval = (mval << 4) | (mval >> 20);
        end
        x.ph = ((nedge / D) % 2) == 1;
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (seg === e.seg) n_pass++;
            else $display("FAIL seg at %0t: got %h expected %h", $time, seg, e.seg);
            n_checks++;
            if (blink_phase === e.ph) n_pass++;
            else $display("FAIL blink_phase at %0t: got %b expected %b", $time, blink_phase, e.ph);
        end else if (stim_done && !report_done) begin
            n_checks++;
            n_pass++;
            report_done = 1'b1;
        end
    end

    initial begin
        mval  = 24'd0;
        nedge = 0;
        // reset and idle
        step(1, 0, 24'h0, 0, 6'h00, 0);
        step(1, 0, 24'h0, 0, 6'h00, 0);
        repeat (10) step(0, 0, 24'h0, 0, 6'h00, 0);
        // plain decode
        step(0, 1, 24'h12AB0F, 0, 6'h00, 0);
        repeat (3) step(0, 0, 24'h0, 0, 6'h00, 0);
        // leading-zero blanking, then value zero
        step(0, 1, 24'h00003C, 1, 6'h00, 0);
        repeat (3) step(0, 0, 24'h0, 1, 6'h00, 0);
        step(0, 1, 24'h000000, 1, 6'h00, 0);
        repeat (3) step(0, 0, 24'h0, 1, 6'h00, 0);
        // blink on two LS digits
        step(0, 1, 24'h123456, 0, 6'b000011, 0);
        repeat (12) step(0, 0, 24'h0, 0, 6'b000011, 0);
        // back-to-back loads, last wins
        step(0, 1, 24'hAAAAAA, 0, 6'h00, 0);
        step(0, 1, 24'h0C0D0E, 1, 6'h00, 0);
        repeat (2) step(0, 0, 24'h0, 1, 6'h00, 0);
        // reset right after a load
        step(0, 1, 24'hFFFFFF, 0, 6'h00, 0);
        step(1, 0, 24'h0, 0, 6'h00, 0);
        repeat (4) step(0, 0, 24'h0, 0, 6'h00, 0);
        // scroll, then a load landing on a wrap
        step(0, 1, 24'h123456, 1, 6'h00, 1);
        repeat (10) step(0, 0, 24'h0, 1, 6'h00, 1);
        while ((nedge % D) != D - 1) step(0, 0, 24'h0, 1, 6'h00, 1);
        step(0, 1, 24'h00ABCD, 1, 6'h00, 1);
        repeat (6) step(0, 0, 24'h0, 1, 6'h00, 0);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($urandom & 32'h000F0F),
                 1'($urandom), ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00,
                 ($urandom_range(0, 3) == 0));
        end
        stim_done = 1'b1;
        repeat (5) begin
            if (!report_done) @(negedge clk);
        end
        #1;
        if (!report_done) $display("FAIL drain: scoreboard still holds %0d entries", q.size());
        $display("%0d/%0d checks passed", n_pass, report_done ? n_checks : n_checks + 1);
        $finish;
    end

endmodule
